// File: rtl/tt_um_nibble_add_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tt_um_nibble_add_seq_pkg
//  Description : Shared definitions for the nibble-serial 16-bit adder:
//                FSM state encoding, pin-index constants, output-enable value.
//  Macro       : NIBBLE_ADD_SEQ_SUB_EN (consumed by the top, not here)
//  Revision    : 1.0 - initial release
// ============================================================================
package tt_um_nibble_add_seq_pkg;

  // Operation phases: gather operands, ripple through the adder, present result
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_ADD  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // uio_in bit positions
  localparam int LD_VALID  = 0;
  localparam int SUB       = 1;
  localparam int RD_ACK    = 2;

  // uio_out bit positions
  localparam int LD_READY  = 4;
  localparam int BUSY      = 5;
  localparam int RES_VALID = 6;
  localparam int CFLAG     = 7;

  // Upper nibble of uio is output, lower nibble is input
  localparam logic [7:0] UIO_OE = 8'hF0;

  // Assemble the status byte driven on uio_out
  function automatic logic [7:0] pack_status(input logic ld_ready,
                                             input logic busy,
                                             input logic res_valid,
                                             input logic cflag);
    logic [7:0] v;
    v            = 8'h00;
    v[LD_READY]  = ld_ready;
    v[BUSY]      = busy;
    v[RES_VALID] = res_valid;
    v[CFLAG]     = cflag;
    return v;
  endfunction

endpackage : tt_um_nibble_add_seq_pkg
`default_nettype wire

// File: rtl/tt_um_nibble_add_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : tt_um_nibble_add_seq_if
//  Description : Pin bundle of the nibble-serial adder (enable, dedicated
//                inputs/outputs, bidirectional uio lanes).
//  Revision    : 1.0 - initial release
// ============================================================================
interface tt_um_nibble_add_seq_if ();

  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  // Driver side (harness / testbench)
  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  // Design side
  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );

endinterface : tt_um_nibble_add_seq_if
`default_nettype wire

// File: rtl/tt_um_nibble_add_seq_nibble_add.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_add
//  Description : 4-bit adder with carry-in and carry-out; the single shared
//                arithmetic element of the nibble-serial datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  // Widen to 5 bits so the carry falls out of the top bit
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule : nibble_add
`default_nettype wire

// File: rtl/tt_um_nibble_add_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tt_um_nibble_add_seq
//  Description : 16-bit add (optionally subtract) computed one nibble per
//                cycle through a single shared 4-bit adder. Operands are
//                loaded LS nibble first, the result is read back the same way
//                under an rd_ack handshake.
//  Macro       : NIBBLE_ADD_SEQ_SUB_EN - when defined, uio_in[1] on the first
//                load beat selects subtract (A + ~B + 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tt_um_nibble_add_seq
  import tt_um_nibble_add_seq_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  tt_um_nibble_add_seq_if.slave   bus
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_cnt;
  logic [3:0][3:0] r_a;
  logic [3:0][3:0] r_b;
  logic [3:0][3:0] r_r;
  logic            r_carry;
  logic            r_cflag;

  logic            w_sub;
  logic [3:0]      w_b_op;
  logic [3:0]      w_sum;
  logic            w_cout;

  logic            w_ld_beat;
  logic            w_add_beat;
  logic            w_rd_beat;
  logic            w_last;
  logic            w_unused_bits;

  // Qualified per-state events; ena=0 kills every one of them, freezing state
  assign w_ld_beat  = bus.ena && (r_state == ST_LOAD) && bus.uio_in[LD_VALID];
  assign w_add_beat = bus.ena && (r_state == ST_ADD);
  assign w_rd_beat  = bus.ena && (r_state == ST_OUT)  && bus.uio_in[RD_ACK];
  assign w_last     = (r_cnt == 2'd3);

`ifdef NIBBLE_ADD_SEQ_SUB_EN
  logic r_sub;

  // Operation select is captured only on the first operand beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub <= 1'b0;
    end else if (w_ld_beat && (r_cnt == 2'd0)) begin
      r_sub <= bus.uio_in[SUB];
    end
  end

  assign w_sub         = r_sub;
  assign w_b_op        = r_b[r_cnt] ^ {4{r_sub}};
  assign w_unused_bits = &{1'b0, bus.uio_in[7:3]};
`else
  assign w_sub         = 1'b0;
  assign w_b_op        = r_b[r_cnt];
  assign w_unused_bits = &{1'b0, bus.uio_in[7:3], bus.uio_in[SUB]};
`endif

  nibble_add u_nibble_add (
    .a    (r_a[r_cnt]),
    .b    (w_b_op),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: each phase advances after its fourth qualified beat
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD: if (w_ld_beat  && w_last) w_state_nxt = ST_ADD;
      ST_ADD:  if (w_add_beat && w_last) w_state_nxt = ST_OUT;
      ST_OUT:  if (w_rd_beat  && w_last) w_state_nxt = ST_LOAD;
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  // Shared nibble counter; natural 2-bit wrap returns it to 0 on phase change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 2'd0;
    end else if (w_ld_beat || w_add_beat || w_rd_beat) begin
      r_cnt <= r_cnt + 2'd1;
    end
  end

  // Operand capture, serial add with carry chaining, final carry flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_carry <= 1'b0;
      r_cflag <= 1'b0;
    end else if (w_ld_beat) begin
      r_a[r_cnt] <= bus.ui_in[3:0];
      r_b[r_cnt] <= bus.ui_in[7:4];
      // Subtract seeds the +1 of the two's-complement through the carry
      if (w_last) begin
        r_carry <= w_sub;
      end
    end else if (w_add_beat) begin
      r_r[r_cnt] <= w_sum;
      r_carry    <= w_cout;
      if (w_last) begin
        r_cflag <= w_cout;
      end
    end
  end

  // Pins: result nibble only while presenting, status from registered state
  assign bus.uo_out  = (r_state == ST_OUT) ? {2'b00, r_cnt, r_r[r_cnt]} : 8'h00;
  assign bus.uio_out = pack_status(r_state == ST_LOAD, r_state == ST_ADD,
                                   r_state == ST_OUT, r_cflag);
  assign bus.uio_oe  = UIO_OE;

endmodule : tt_um_nibble_add_seq
`default_nettype wire

// File: tb/tb_tt_um_nibble_add_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tt_um_nibble_add_seq
//  Description : Directed table-driven bench for the nibble-serial adder,
//                plus hand sequences for hold, stall and mid-operation reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_um_nibble_add_seq;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] r;
    logic        c;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   lat;
  vec_t tbl [6];

  always #5 clk = ~clk;

  tt_um_nibble_add_seq_if bus ();

  tt_um_nibble_add_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Four operand beats; on return the DUT has just taken the last beat
  task automatic load_beats(input logic [15:0] a, input logic [15:0] b, input logic sub);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.ena    = 1'b1;
      bus.ui_in  = {b[i*4 +: 4], a[i*4 +: 4]};
      // rd_ack held high (must be ignored); sub inverted after beat 0
      bus.uio_in = {5'b00000, 1'b1, (i == 0) ? sub : ~sub, 1'b1};
    end
    @(posedge clk);
    #1;
    bus.uio_in = 8'h00;
  endtask

  // Load then count edges until res_valid, with ena low for the first 'stall'
  task automatic load_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         input int stall, output int l);
    load_beats(a, b, sub);
    l = 0;
    while (!bus.uio_out[6] && l < 30) begin
      bus.ena = (l < stall) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      l++;
    end
    bus.ena = 1'b1;
  endtask

  task automatic read_out(input string tag, input logic [15:0] r, input logic c);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_nib%0d", tag, i), {12'h000, bus.uo_out[3:0]}, {12'h000, r[i*4 +: 4]});
      check($sformatf("%s_idx%0d", tag, i), {14'h0000, bus.uo_out[5:4]}, i[15:0]);
      check($sformatf("%s_rv%0d", tag, i), {15'h0000, bus.uio_out[6]}, 16'h0001);
      if (i == 0) check($sformatf("%s_cflag", tag), {15'h0000, bus.uio_out[7]}, {15'h0000, c});
      bus.uio_in = 8'h04;
      @(posedge clk);
      #1;
      bus.uio_in = 8'h00;
    end
    // Back in LOAD with the flag still visible
    check($sformatf("%s_after", tag), {8'h00, bus.uio_out}, {8'h00, c, 7'h10});
  endtask

  initial begin
    tbl[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    tbl[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    tbl[3] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0};
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    tbl[4] = '{16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1};
    tbl[5] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0};
`else
    tbl[4] = '{16'h0005, 16'h0003, 1'b1, 16'h0008, 1'b0};
    tbl[5] = '{16'h0003, 16'h0005, 1'b1, 16'h0008, 1'b0};
`endif

    bus.ena    = 1'b1;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_uo",     {8'h00, bus.uo_out},  16'h0000);
    check("rst_uio",    {8'h00, bus.uio_out}, 16'h0010);
    check("rst_oe",     {8'h00, bus.uio_oe},  16'h00F0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 6; k++) begin
      load_op(tbl[k].a, tbl[k].b, tbl[k].sub, 0, lat);
      check($sformatf("v%0d_lat", k), lat[15:0], 16'd4);
      read_out($sformatf("v%0d", k), tbl[k].r, tbl[k].c);
    end

    // Result held without rd_ack; ld_valid pulses in OUT ignored
    load_op(16'h1234, 16'h1111, 1'b0, 0, lat);
    check("hold_lat", lat[15:0], 16'd4);
    for (int j = 0; j < 5; j++) begin
      bus.ui_in  = 8'hFF;
      bus.uio_in = (j % 2 == 1) ? 8'h01 : 8'h00;
      @(posedge clk);
      #1;
      check($sformatf("hold%0d", j), {8'h00, bus.uo_out}, 16'h0005);
    end
    bus.uio_in = 8'h00;
    read_out("hold", 16'h2345, 1'b0);

    // ena low during ADD stretches latency by the stalled cycles
    load_op(16'hABCD, 16'h1234, 1'b0, 3, lat);
    check("stall_lat", lat[15:0], 16'd7);
    read_out("stall", 16'hBE01, 1'b0);

    // Reset on the second ADD cycle discards the operation at once
    load_beats(16'hFFFF, 16'h0001, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_uo",  {8'h00, bus.uo_out},  16'h0000);
    check("mid_rst_uio", {8'h00, bus.uio_out}, 16'h0010);
    check("mid_rst_oe",  {8'h00, bus.uio_oe},  16'h00F0);
    @(negedge clk);
    rst_n = 1'b1;
    load_op(16'h1234, 16'h1111, 1'b0, 0, lat);
    check("post_rst_lat", lat[15:0], 16'd4);
    read_out("post_rst", 16'h2345, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_tt_um_nibble_add_seq
`default_nettype wire

// File: doc/tt_um_nibble_add_seq.md
TT_UM_NIBBLE_ADD_SEQ -- requirements
Module: tt_um_nibble_add_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; all ports below are fixed.
REQ-002 clk  input  1  clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ena  input  1  1 = advance; 0 = hold all state.
REQ-005 ui_in  input  8  [3:0] operand-A nibble, [7:4] operand-B nibble.
REQ-006 uio_in  input  8  [0] ld_valid, [1] sub (macro-gated), [2] rd_ack, [7:3] ignored.
REQ-007 uo_out  output  8  [3:0] result nibble, [5:4] nibble index, [7:6] 0.
REQ-008 uio_out  output  8  [4] ld_ready, [5] busy, [6] res_valid, [7] cflag, [3:0] 0.
REQ-009 uio_oe  output  8  constant 8'hF0.

Function
REQ-010 SHALL sequence one shared 4-bit adder to form 16-bit A op B over 4 cycles, LS nibble first.
REQ-011 States: LOAD, ADD, OUT; 2-bit nibble counter cnt shared by all states.
REQ-012 LOAD: ld_ready=1; each cycle with ld_valid=1, store ui_in[3:0] at A[cnt], ui_in[7:4] at B[cnt], cnt+1.
REQ-013 LOAD, cnt=3 with ld_valid=1 -> ADD, cnt=0, carry register = latched sub (0 when add).
REQ-014 Latched sub SHALL be sampled only on the cnt=0 load beat.
REQ-015 ADD: busy=1; per cycle R[cnt] = A[cnt] + (B[cnt] XOR {4{sub}}) + carry; carry <= carry-out; cnt+1; no stall.
REQ-016 ADD, cnt=3 -> OUT, cnt=0, cflag = final carry-out; exactly 4 cycles from last load beat to res_valid.
REQ-017 OUT: res_valid=1; uo_out[3:0]=R[cnt], uo_out[5:4]=cnt; nibble held until rd_ack=1.
REQ-018 OUT with rd_ack=1: cnt+1; at cnt=3 -> LOAD, cnt=0; cflag held until next ADD completes.
REQ-019 ld_valid SHALL be ignored outside LOAD; rd_ack ignored outside OUT.
REQ-020 ena=0 SHALL freeze state, cnt, registers, and outputs regardless of other inputs.
REQ-021 Arithmetic modulo 2^16; cflag = carry out of bit 15 (add: overflow; sub: 1 = no borrow).

Reset
REQ-022 rst_n=0 SHALL immediately force LOAD, cnt=0, A=B=R=0, carry=0, sub=0, cflag=0.
REQ-023 Reset values: uo_out=0, uio_out=8'h10 (ld_ready only), uio_oe=8'hF0.
REQ-024 Reset asserted mid-LOAD/ADD/OUT SHALL discard the operation; no partial result visible.

Configuration
REQ-025 Macro NIBBLE_ADD_SEQ_SUB_EN defined: uio_in[1] selects subtract per REQ-013..015.
REQ-026 Macro undefined: uio_in[1] ignored, sub constant 0, add-only, no XOR/sub register logic.

Structure
REQ-027 Shared package SHALL hold state encoding, pin-index constants (LD_VALID, SUB, RD_ACK, LD_READY, BUSY, RES_VALID, CFLAG), and UIO_OE value.
REQ-028 Single sub-module nibble_add (4-bit a, b, cin -> 4-bit sum, cout) SHALL be instantiated once and shared across all ADD cycles.

Verification
REQ-029 Load (4,1),(3,1),(2,1),(1,1) -> res_valid 4 cycles after last beat; nibbles 5,4,3,2 (0x2345); cflag=0.
REQ-030 0xFFFF+0x0001 -> result 0x0000, cflag=1 (carry ripples through all 4 ADD cycles).
REQ-031 With macro: 0x0005-0x0003 -> 0x0002, cflag=1; 0x0003-0x0005 -> 0xFFFE, cflag=0; without macro, sub=1 on 0x0005,0x0003 -> 0x0008.
REQ-032 rst_n pulsed low on 2nd ADD cycle -> outputs at reset values same cycle; next full load yields correct sum.
REQ-033 In OUT hold rd_ack=0 for 5 cycles -> nibble 0 stable; ld_valid pulses ignored; ena=0 in ADD stretches latency by the stalled cycles.
